shot_trigger_ctrl: RTL and testbench

- Producer side of the fire/error interface consumed by the BCD shot counter and display block.
- Debounces raw trigger and reload push-buttons and tracks a magazine count.
- Emits one clean, registered fire pulse per accepted shot, and a registered error pulse when the trigger is pulled on an empty magazine.
- fire and error are driven directly from flops, glitch-free, because downstream logic clocks on posedge fire.

---
 rtl/shot_pkg.sv | 36 +++
 rtl/shot_trigger_ctrl_debounce.sv | 66 ++++++
 rtl/shot_trigger_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_shot_trigger_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shot_pkg
//  Description : Shared definitions for the shot trigger controller:
//                FSM state encoding, ammo counter width, default cycle counts
//                and a small helper for deriving timer widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package shot_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FIRE     = 3'd1,
        ST_COOLDOWN = 3'd2,
        ST_RELOAD   = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    // Width of the rounds-remaining counter (holds 0..15)
    localparam int AMMO_W = 4;

    // Default cycle counts, assuming a 100 MHz clock
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 10 ms
    localparam int DEF_FIRE_WIDTH      = 4;
    localparam int DEF_COOLDOWN_CYCLES = 25000000;  // 250 ms
    localparam int DEF_RELOAD_CYCLES   = 50000000;  // 500 ms
    localparam int DEF_MAG_SIZE        = 12;
    localparam int DEF_ERR_WIDTH       = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : shot_pkg
`default_nettype wire

// File: rtl/shot_trigger_ctrl_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Raw push-button conditioner. Two-flop synchronizer, then a
//                stability counter that only moves the accepted level after
//                the synchronized input has disagreed with it for
//                DEBOUNCE_CYCLES consecutive cycles (any bounce restarts the
//                count), then a one-cycle rising-edge event.
//  Ports       : clk, reset (async, active-high)
//                i_btn    - raw asynchronous button
//                o_level  - debounced level
//                o_event  - one-cycle pulse on a debounced rising edge
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import shot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_event
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            if (r_sync2 != r_level) begin
                // The final disagreeing sample commits the new level
                if (r_cnt == c_CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    // Both terms are flops, so the event is clean for the FSM in the same domain
    assign o_event = r_level & ~r_level_d;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/shot_trigger_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shot_trigger_ctrl
//  Description : Fire/error producer for the shot counter and display block.
//                Debounces the trigger and reload buttons, tracks magazine
//                contents and emits one registered fire pulse per accepted
//                shot, or a registered error pulse on an empty magazine.
//  Ports       : clk        - system clock
//                reset      - asynchronous, active-high
//                enable     - gates acceptance of new shots/reloads in IDLE
//                trig_btn   - raw trigger button
//                reload_btn - raw reload button
//                fire       - FIRE_WIDTH-cycle shot pulse (flop output)
//                error      - ERR_WIDTH-cycle empty-magazine pulse (flop output)
//                ammo       - rounds remaining, 0..MAG_SIZE
//                busy       - high whenever the controller is not IDLE
//  Build option: define SHOT_AUTO_FIRE_EN for automatic fire while the
//                trigger is held.
//  Revision    : 1.0 - initial release
// ============================================================================
module shot_trigger_ctrl
    import shot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int FIRE_WIDTH      = DEF_FIRE_WIDTH,
    parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
    parameter int RELOAD_CYCLES   = DEF_RELOAD_CYCLES,
    parameter int MAG_SIZE        = DEF_MAG_SIZE,
    parameter int ERR_WIDTH       = DEF_ERR_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              trig_btn,
    input  logic              reload_btn,
    output logic              fire,
    output logic              error,
    output logic [AMMO_W-1:0] ammo,
    output logic              busy
);

    // One shared timer, sized for the longest interval it has to count
    localparam int TIMER_MAX = max2(max2(FIRE_WIDTH, ERR_WIDTH),
                                    max2(COOLDOWN_CYCLES, RELOAD_CYCLES));
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0] c_FIRE_LAST   = TIMER_W'(FIRE_WIDTH - 1);
    // Cooldown counts 0..COOLDOWN_CYCLES so a held trigger repeats every
    // FIRE_WIDTH + COOLDOWN_CYCLES + 1 cycles
    localparam logic [TIMER_W-1:0] c_COOL_LAST   = TIMER_W'(COOLDOWN_CYCLES);
    localparam logic [TIMER_W-1:0] c_RELOAD_LAST = TIMER_W'(RELOAD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_ERR_LAST    = TIMER_W'(ERR_WIDTH - 1);
    localparam logic [AMMO_W-1:0]  c_MAG         = AMMO_W'(MAG_SIZE);

    logic w_trig_level;
    logic w_trig_ev;
    logic w_reload_level;
    logic w_reload_ev;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic [AMMO_W-1:0]  r_ammo;
    logic [AMMO_W-1:0]  w_ammo_nxt;
    logic               r_fire;
    logic               r_error;
    logic               r_busy;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_trig_db (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (trig_btn),
        .o_level (w_trig_level),
        .o_event (w_trig_ev)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_reload_db (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (reload_btn),
        .o_level (w_reload_level),
        .o_event (w_reload_ev)
    );

    // Levels not consumed by the FSM in this build
`ifdef SHOT_AUTO_FIRE_EN
    logic w_unused_levels;
    assign w_unused_levels = &{1'b0, w_reload_level};
`else
    logic w_unused_levels;
    assign w_unused_levels = &{1'b0, w_reload_level, w_trig_level};
`endif

    // ------------------------------------------------------------------
    // Next-state logic; the timer restarts from zero on every state entry
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + TIMER_W'(1);
        w_ammo_nxt  = r_ammo;

        case (r_state)
            ST_IDLE: begin
                w_timer_nxt = '0;
                if (enable) begin
                    // Reload has priority; a coincident trigger event is dropped
                    if (w_reload_ev) begin
                        w_state_nxt = ST_RELOAD;
                    end else if (w_trig_ev) begin
                        if (r_ammo != '0) begin
                            w_state_nxt = ST_FIRE;
                            w_ammo_nxt  = r_ammo - AMMO_W'(1);
                        end else begin
                            w_state_nxt = ST_ERROR;
                        end
                    end
                end
            end

            ST_FIRE: begin
                if (r_timer == c_FIRE_LAST) begin
                    w_state_nxt = ST_COOLDOWN;
                    w_timer_nxt = '0;
                end
            end

            ST_COOLDOWN: begin
                if (r_timer == c_COOL_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_IDLE;
`ifdef SHOT_AUTO_FIRE_EN
                    // Held trigger: repeat directly; on an empty magazine the
                    // single error pulse returns to IDLE, which needs a fresh
                    // edge, so it cannot repeat
                    if (enable && w_trig_level) begin
                        if (r_ammo != '0) begin
                            w_state_nxt = ST_FIRE;
                            w_ammo_nxt  = r_ammo - AMMO_W'(1);
                        end else begin
                            w_state_nxt = ST_ERROR;
                        end
                    end
`endif
                end
            end

            ST_RELOAD: begin
                if (r_timer == c_RELOAD_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                    w_ammo_nxt  = c_MAG;
                end
            end

            ST_ERROR: begin
                if (r_timer == c_ERR_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. Outputs are decoded from the next state
    // so they are flop outputs aligned with the state they belong to.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_ammo  <= c_MAG;
            r_fire  <= 1'b0;
            r_error <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_ammo  <= w_ammo_nxt;
            r_fire  <= (w_state_nxt == ST_FIRE);
            r_error <= (w_state_nxt == ST_ERROR);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign fire  = r_fire;
    assign error = r_error;
    assign busy  = r_busy;
    assign ammo  = r_ammo;

endmodule : shot_trigger_ctrl
`default_nettype wire

// File: tb/tb_shot_trigger_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shot_trigger_ctrl
//  Description : Scoreboard bench for shot_trigger_ctrl. Stimulus pushes the
//                expected fire, error and busy pulses (start cycle, width,
//                ammo); a negedge monitor measures each pulse the DUT emits
//                and compares it against the head of the matching queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shot_trigger_ctrl;

    localparam int DEB  = 4;
    localparam int FW   = 4;
    localparam int COOL = 10;
    localparam int REL  = 20;
    localparam int MAG  = 3;
    localparam int EW   = 4;
    // Raw press (driven just after edge P) to first cycle of fire/error/busy
    localparam int LAT  = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       trig_btn;
    logic       reload_btn;
    logic       fire;
    logic       error;
    logic [3:0] ammo;
    logic       busy;

    shot_trigger_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .FIRE_WIDTH      (FW),
        .COOLDOWN_CYCLES (COOL),
        .RELOAD_CYCLES   (REL),
        .MAG_SIZE        (MAG),
        .ERR_WIDTH       (EW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .trig_btn   (trig_btn),
        .reload_btn (reload_btn),
        .fire       (fire),
        .error      (error),
        .ammo       (ammo),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        int start;
        int width;
        int ammo;
    } exp_t;

    exp_t q_fire[$];
    exp_t q_err[$];
    exp_t q_busy[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // kind: 0 = fire, 1 = error, 2 = busy
    task automatic compare(input int kind, input int s, input int w, input int a);
        exp_t  e;
        bit    have;
        string nm;
        have = 1'b0;
        nm   = (kind == 0) ? "fire" : (kind == 1) ? "error" : "busy";
        case (kind)
            0: if (q_fire.size() > 0) begin e = q_fire.pop_front(); have = 1'b1; end
            1: if (q_err.size()  > 0) begin e = q_err.pop_front();  have = 1'b1; end
            default: if (q_busy.size() > 0) begin e = q_busy.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            failures++;
            $display("FAIL unexpected_%s: got pulse start=%0d width=%0d required none", nm, s, w);
        end else begin
            chk({nm, "_start"}, s, e.start);
            chk({nm, "_width"}, w, e.width);
            chk({nm, "_ammo"},  a, e.ammo);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    initial begin
        logic pf, pe, pb;
        int   fs, fw, fa, es, ew, ea, bs, bw;
        pf = 1'b0; pe = 1'b0; pb = 1'b0;
        fs = 0; fw = 0; fa = 0; es = 0; ew = 0; ea = 0; bs = 0; bw = 0;
        forever begin
            @(negedge clk);
            if (fire || error)
                chk("fire_error_exclusive", int'(fire && error), 0);
            if (fire) begin
                if (!pf) begin fs = cyc; fw = 0; fa = int'(ammo); end
                fw++;
            end else if (pf) begin
                compare(0, fs, fw, fa);
            end
            if (error) begin
                if (!pe) begin es = cyc; ew = 0; ea = int'(ammo); end
                ew++;
            end else if (pe) begin
                compare(1, es, ew, ea);
            end
            if (busy) begin
                if (!pb) begin bs = cyc; bw = 0; end
                bw++;
            end else if (pb) begin
                compare(2, bs, bw, int'(ammo));
            end
            pf = fire;
            pe = error;
            pb = busy;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic exp_shot(input int p, input int ammo_after);
        q_fire.push_back('{start: p + LAT, width: FW, ammo: ammo_after});
        q_busy.push_back('{start: p + LAT, width: FW + COOL + 1, ammo: ammo_after});
    endtask

    task automatic press_trig(input int ammo_after);
        exp_shot(cyc, ammo_after);
        trig_btn = 1'b1;
        step(10);
        trig_btn = 1'b0;
        step(30);
    endtask

    initial begin
        int p;
        reset      = 1'b1;
        enable     = 1'b1;
        trig_btn   = 1'b0;
        reload_btn = 1'b0;
        step(3);
        chk("reset_fire",  int'(fire),  0);
        chk("reset_error", int'(error), 0);
        chk("reset_busy",  int'(busy),  0);
        chk("reset_ammo",  int'(ammo),  MAG);
        reset = 1'b0;
        step(5);

        // Clean press
        press_trig(2);
        chk("clean_ammo", int'(ammo), 2);

        // Bouncing press: only the last rising edge leads to a shot
        trig_btn = 1'b1; step(2);
        trig_btn = 1'b0; step(2);
        trig_btn = 1'b1; step(2);
        trig_btn = 1'b0; step(2);
        press_trig(1);
        chk("bounce_ammo", int'(ammo), 1);

        // Refill via reset, empty the magazine, then error, then reload
        reset = 1'b1; step(2); reset = 1'b0; step(3);
        chk("refill_ammo", int'(ammo), MAG);
        for (int i = 0; i < 3; i++)
            press_trig(MAG - 1 - i);
        chk("empty_ammo", int'(ammo), 0);
        p = cyc;
        q_err.push_back('{start: p + LAT, width: EW, ammo: 0});
        q_busy.push_back('{start: p + LAT, width: EW, ammo: 0});
        trig_btn = 1'b1; step(10); trig_btn = 1'b0; step(30);
        p = cyc;
        q_busy.push_back('{start: p + LAT, width: REL, ammo: MAG});
        reload_btn = 1'b1; step(10); reload_btn = 1'b0; step(30);
        chk("reload_ammo", int'(ammo), MAG);

        // Trigger and reload on the same cycle: reload wins
        press_trig(2);
        p = cyc;
        q_busy.push_back('{start: p + LAT, width: REL, ammo: MAG});
        trig_btn = 1'b1; reload_btn = 1'b1; step(10);
        trig_btn = 1'b0; reload_btn = 1'b0; step(30);
        chk("tie_ammo", int'(ammo), MAG);

`ifndef SHOT_AUTO_FIRE_EN
        // Second press lands during cooldown and is discarded
        exp_shot(cyc, 2);
        trig_btn = 1'b1; step(5); trig_btn = 1'b0; step(6);
        trig_btn = 1'b1; step(5); trig_btn = 1'b0; step(30);
        chk("cooldown_drop_ammo", int'(ammo), 2);
`else
        press_trig(2);
`endif

        // Reset on the second cycle of fire
        p = cyc;
        q_fire.push_back('{start: p + LAT, width: 1, ammo: 1});
        q_busy.push_back('{start: p + LAT, width: 1, ammo: MAG});
        trig_btn = 1'b1;
        step(8);
        reset    = 1'b1;
        trig_btn = 1'b0;
        #1;
        chk("midfire_reset_fire", int'(fire), 0);
        chk("midfire_reset_busy", int'(busy), 0);
        chk("midfire_reset_ammo", int'(ammo), MAG);
        step(2);
        reset = 1'b0;
        step(5);

        // Press while disabled: nothing happens
        enable = 1'b0;
        trig_btn = 1'b1; step(10); trig_btn = 1'b0; step(30);
        enable = 1'b1;
        step(5);
        chk("disabled_ammo", int'(ammo), MAG);
        chk("disabled_busy", int'(busy), 0);

`ifdef SHOT_AUTO_FIRE_EN
        // Held trigger empties the magazine, then one error pulse
        p = cyc;
        q_fire.push_back('{start: p + LAT,      width: FW, ammo: 2});
        q_fire.push_back('{start: p + LAT + 15, width: FW, ammo: 1});
        q_fire.push_back('{start: p + LAT + 30, width: FW, ammo: 0});
        q_err.push_back('{start: p + LAT + 45,  width: EW, ammo: 0});
        q_busy.push_back('{start: p + LAT, width: 49, ammo: 0});
        trig_btn = 1'b1; step(100); trig_btn = 1'b0; step(30);
        chk("auto_ammo", int'(ammo), 0);
`endif

        chk("pending_fire",  q_fire.size(), 0);
        chk("pending_error", q_err.size(),  0);
        chk("pending_busy",  q_busy.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_shot_trigger_ctrl
`default_nettype wire
